rsa_ct_uart_framer: RTL



---
 rtl/rsa_link_pkg.sv | 35 +++
 rtl/uart_tx_byte.sv | 117 +++++++++++
 rtl/rsa_ct_uart_framer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rsa_link_pkg.sv
// Shared definitions for the RSA ciphertext UART link: frame constants,
// the serializer state encoding and the frame checksum / byte selection helpers.
package rsa_link_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_BYTES       = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    NEXT  = 3'd4
  } framer_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] sync, input logic [15:0] ct);
    return sync ^ ct[15:8] ^ ct[7:0];
  endfunction

  // Frame byte order on the wire: SYNC, CT high, CT low, CHK.
  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [15:0] ct,
                                            input logic [7:0]  chk);
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync;
      2'd1:    b = ct[15:8];
      2'd2:    b = ct[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request accepted in the last cycle of a stop bit
// begins the next start bit immediately, so consecutive bytes have no idle gap.
module uart_tx_byte
  import rsa_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  framer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);
  assign done_o    = (state_q == STOP) && bit_end_s;
  assign busy_o    = (state_q != IDLE);
  assign tx_o      = tx_q;

  // Next-state: the baud counter reloads at every bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_W'(0);
        if (start_i) begin
          state_d = START;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = CNT_W'(0);
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_W'(0);
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = CNT_W'(0);
          if (start_i) begin
            state_d = START;
            shreg_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; the line idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/rsa_ct_uart_framer.sv
// Frames each new rsa_encryptor ciphertext as SYNC, CT[15:8], CT[7:0], CHK over
// UART 8N1, holding one pending result while a frame is on the line.
module rsa_ct_uart_framer
  import rsa_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ct_valid,
  input  logic [15:0] ciphertext,
  output logic        tx,
  output logic        busy,
  output logic        frame_sent,
  output logic        overrun
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic        ct_valid_q;
  logic [15:0] ct_q, ct_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic        overrun_q, overrun_d;
  logic        frame_sent_q, frame_sent_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic        taken_s;
  logic        ser_start_s;
  logic [7:0]  ser_data_s;
  logic        ser_busy_s;
  logic        ser_done_s;

  assign accept_s = ct_valid && !ct_valid_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(ser_start_s),
    .data_i (ser_data_s),
    .tx_o   (tx),
    .busy_o (ser_busy_s),
    .done_o (ser_done_s)
  );

  // Byte sequencing. At the end of the last byte the stored pending entry wins;
  // a coinciding accept then starts directly only if nothing was pending.
  always_comb begin
    ct_d         = ct_q;
    chk_d        = chk_q;
    byte_idx_d   = byte_idx_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    overrun_d    = overrun_q;
    frame_sent_d = 1'b0;
    ser_start_s  = 1'b0;
    ser_data_s   = SYNC_BYTE;
    taken_s      = 1'b0;

    if (!ser_busy_s) begin
      if (accept_s) begin
        ct_d        = ciphertext;
        chk_d       = frame_chk(SYNC_BYTE, ciphertext);
        byte_idx_d  = 2'd0;
        ser_start_s = 1'b1;
        taken_s     = 1'b1;
      end else begin
        ser_start_s = 1'b0;
      end
    end else if (ser_done_s) begin
      if (byte_idx_q != LAST_BYTE) begin
        byte_idx_d  = byte_idx_q + 2'd1;
        ser_start_s = 1'b1;
        ser_data_s  = frame_byte(byte_idx_d, SYNC_BYTE, ct_q, chk_q);
      end else begin
        frame_sent_d = 1'b1;
        byte_idx_d   = 2'd0;
        if (pend_full_q) begin
          ct_d        = pend_q;
          chk_d       = frame_chk(SYNC_BYTE, pend_q);
          pend_full_d = 1'b0;
          ser_start_s = 1'b1;
        end else if (accept_s) begin
          ct_d        = ciphertext;
          chk_d       = frame_chk(SYNC_BYTE, ciphertext);
          ser_start_s = 1'b1;
          taken_s     = 1'b1;
        end else begin
          ser_start_s = 1'b0;
        end
      end
    end else begin
      ser_start_s = 1'b0;
    end

    if (accept_s && !taken_s) begin
      if (!pend_full_d) begin
        pend_d      = ciphertext;
        pend_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = ser_start_s | (ser_busy_s & ~ser_done_s) | pend_full_d | frame_sent_d;
  end

  // Framer registers; reset discards any frame in flight and the pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_valid_q   <= 1'b0;
      ct_q         <= 16'd0;
      chk_q        <= 8'd0;
      byte_idx_q   <= 2'd0;
      pend_q       <= 16'd0;
      pend_full_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_sent_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ct_valid_q   <= ct_valid;
      ct_q         <= ct_d;
      chk_q        <= chk_d;
      byte_idx_q   <= byte_idx_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      overrun_q    <= overrun_d;
      frame_sent_q <= frame_sent_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign frame_sent = frame_sent_q;
  assign overrun    = overrun_q;

endmodule
